control_sequencer: RTL and testbench

Control unit directly downstream of the 2-bit sequence counter. It consumes timing state T[1:0] and generates the counter's freeze/restart enable E plus per-phase micro-operation strobes for a 3-bit-opcode accumulator datapath. It owns instruction latching, data-memory wait handling with timeout, start-up arming, and halt. The counter holds T while E=1; when E falls from 1 to 0, T restarts at 0 on the following edge.

---
 rtl/control_pkg.sv | 29 ++
 rtl/control_sequencer_if.sv | 36 +++
 rtl/opcode_decoder.sv | 20 ++
 rtl/control_sequencer.sv | 154 +++++++++++++++
 tb/tb_control_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the control sequencer: opcodes, timing phases, FSM states.
package control_pkg;

    // 3-bit opcodes of the accumulator datapath
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_CLR = 3'b100;
    localparam logic [2:0] OP_INC = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    // Timing phases produced by the 2-bit sequence counter
    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        WAIT,
        HALT
    } state_e;

endpackage

// File: rtl/control_sequencer_if.sv
// Signal bundle between the sequence counter / memories and the control sequencer.
interface control_sequencer_if;

    logic [1:0] T;
    logic       start;
    logic [2:0] instr;
    logic       mem_ready;

    logic       E;
    logic       ir_ld;
    logic       pc_inc;
    logic       pc_ld;
    logic       mem_rd;
    logic       mem_wr;
    logic       ac_ld_mem;
    logic       ac_add;
    logic       ac_clr;
    logic       ac_inc;
    logic       halted;
    logic       err;

    // Environment side: supplies timing, start, opcode and memory handshake
    modport master (
        output T, start, instr, mem_ready,
        input  E, ir_ld, pc_inc, pc_ld, mem_rd, mem_wr,
               ac_ld_mem, ac_add, ac_clr, ac_inc, halted, err
    );

    // Sequencer side
    modport slave (
        input  T, start, instr, mem_ready,
        output E, ir_ld, pc_inc, pc_ld, mem_rd, mem_wr,
               ac_ld_mem, ac_add, ac_clr, ac_inc, halted, err
    );

endinterface

// File: rtl/opcode_decoder.sv
// Classifies a latched opcode into the flags shared by the RUN and WAIT logic.
module opcode_decoder
    import control_pkg::*;
(
    input  logic [2:0] op,
    output logic       is_mem,
    output logic       is_rd,
    output logic       is_alu,
    output logic       is_hlt
);

    // Pure decode of the opcode class
    always_comb begin
        is_mem = (op == OP_LDA) || (op == OP_STA);
        is_rd  = (op == OP_LDA);
        is_alu = (op == OP_ADD) || (op == OP_CLR) || (op == OP_INC);
        is_hlt = (op == OP_HLT);
    end

endmodule

// File: rtl/control_sequencer.sv
// Control unit downstream of the 2-bit sequence counter: generates the counter
// freeze enable E and per-phase micro-operation strobes, handling instruction
// latching, data-memory waits with timeout, start-up arming and halt.
module control_sequencer
    import control_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input logic                clk,
    input logic                rst,
    control_sequencer_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;

    logic is_mem, is_rd, is_alu, is_hlt;

    logic e, ir_ld, pc_inc, pc_ld, mem_rd, mem_wr;
    logic ac_ld_mem, ac_add, ac_clr, ac_inc;

    opcode_decoder u_dec (
        .op    (op_q),
        .is_mem(is_mem),
        .is_rd (is_rd),
        .is_alu(is_alu),
        .is_hlt(is_hlt)
    );

    // State, opcode, wait counter and sticky error registers
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and strobe decode from state, T phase, opcode and mem_ready
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        op_d      = op_q;
        wcnt_d    = wcnt_q;
        err_d     = err_q;
        e         = 1'b1;
        ir_ld     = 1'b0;
        pc_inc    = 1'b0;
        pc_ld     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        ac_ld_mem = 1'b0;
        ac_add    = 1'b0;
        ac_clr    = 1'b0;
        ac_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) state_d = ARM;
            end

            // One cycle with E low to absorb the counter's restart-on-release T0
            ARM: begin
                e       = 1'b0;
                state_d = RUN;
            end

            RUN: begin
                e = 1'b0;
                case (bus.T)
                    T0: begin
                        ir_ld = 1'b1;
                        op_d  = bus.instr;
                    end
                    T1: pc_inc = 1'b1;
                    T2: begin
                        if (is_mem) begin
                            mem_rd = is_rd;
                            mem_wr = !is_rd;
                            if (bus.mem_ready) begin
                                ac_ld_mem = is_rd;
                            end else begin
                                e       = 1'b1;
                                wcnt_d  = CW'(1);
                                state_d = WAIT;
                            end
                        end else if (op_q == OP_JMP) begin
                            pc_ld = 1'b1;
                        end else if (is_hlt) begin
                            e       = 1'b1;
                            state_d = HALT;
                        end
                    end
                    default: begin
                        if (is_alu) begin
                            ac_add = (op_q == OP_ADD);
                            ac_clr = (op_q == OP_CLR);
                            ac_inc = (op_q == OP_INC);
                        end
                    end
                endcase
            end

            // T frozen at T2; request held until completion or timeout
            WAIT: begin
                mem_rd = is_rd;
                mem_wr = !is_rd;
                if (bus.mem_ready) begin
                    e         = 1'b0;
                    ac_ld_mem = is_rd;
                    wcnt_d    = '0;
                    state_d   = RUN;
                end else if (wcnt_q < TIMEOUT_C) begin
                    wcnt_d = wcnt_q + CW'(1);
                end else begin
                    mem_rd  = 1'b0;
                    mem_wr  = 1'b0;
                    err_d   = 1'b1;
                    state_d = HALT;
                end
            end

            default: begin
                // HALT: hold the counter; only rst leaves
            end
        endcase
    end

    assign bus.E         = e;
    assign bus.ir_ld     = ir_ld;
    assign bus.pc_inc    = pc_inc;
    assign bus.pc_ld     = pc_ld;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.ac_ld_mem = ac_ld_mem;
    assign bus.ac_add    = ac_add;
    assign bus.ac_clr    = ac_clr;
    assign bus.ac_inc    = ac_inc;
    assign bus.halted    = (state_q == HALT);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: two instances (TIMEOUT 15 and 4), each
// fed by a behavioural model of the 2-bit sequence counter.
module tb_control_sequencer;
    import control_pkg::*;

    // Output vector bit masks: {E,ir_ld,pc_inc,pc_ld,mem_rd,mem_wr,ac_ld_mem,ac_add,ac_clr,ac_inc,halted,err}
    localparam logic [11:0] B_E   = 12'h800;
    localparam logic [11:0] B_IR  = 12'h400;
    localparam logic [11:0] B_PCI = 12'h200;
    localparam logic [11:0] B_PCL = 12'h100;
    localparam logic [11:0] B_RD  = 12'h080;
    localparam logic [11:0] B_WR  = 12'h040;
    localparam logic [11:0] B_LDM = 12'h020;
    localparam logic [11:0] B_ADD = 12'h010;
    localparam logic [11:0] B_CLR = 12'h008;
    localparam logic [11:0] B_INC = 12'h004;
    localparam logic [11:0] B_HLT = 12'h002;
    localparam logic [11:0] B_ERR = 12'h001;
    localparam logic [11:0] NONE  = 12'h000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] instr = OP_NOP;
    logic       mem_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    control_sequencer_if i15 ();
    control_sequencer_if i4 ();

    control_sequencer #(.TIMEOUT(15)) dut15 (.clk(clk), .rst(rst), .bus(i15.slave));
    control_sequencer #(.TIMEOUT(4))  dut4  (.clk(clk), .rst(rst), .bus(i4.slave));

    assign i15.start     = start;
    assign i15.instr     = instr;
    assign i15.mem_ready = mem_ready;
    assign i4.start      = start;
    assign i4.instr      = instr;
    assign i4.mem_ready  = mem_ready;

    // Sequence counter models: hold while E=1, restart at 0 after E falls, else count
    logic [1:0] t15, t4;
    logic       ep15, ep4;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t15 <= 2'd0; ep15 <= 1'b1;
            t4  <= 2'd0; ep4  <= 1'b1;
        end else begin
            if (i15.E)     t15 <= t15;
            else if (ep15) t15 <= 2'd0;
            else           t15 <= t15 + 2'd1;
            ep15 <= i15.E;
            if (i4.E)      t4 <= t4;
            else if (ep4)  t4 <= 2'd0;
            else           t4 <= t4 + 2'd1;
            ep4 <= i4.E;
        end
    end

    assign i15.T = t15;
    assign i4.T  = t4;

    logic [11:0] outs15, outs4;
    assign outs15 = {i15.E, i15.ir_ld, i15.pc_inc, i15.pc_ld, i15.mem_rd, i15.mem_wr,
                     i15.ac_ld_mem, i15.ac_add, i15.ac_clr, i15.ac_inc, i15.halted, i15.err};
    assign outs4  = {i4.E, i4.ir_ld, i4.pc_inc, i4.pc_ld, i4.mem_rd, i4.mem_wr,
                     i4.ac_ld_mem, i4.ac_add, i4.ac_clr, i4.ac_inc, i4.halted, i4.err};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check T and outputs mid-cycle
    task automatic cyc(input bit sel4, input logic s, input logic [2:0] ins, input logic rdy,
                       input string tag, input logic [1:0] exp_t, input logic [11:0] exp_o);
        @(posedge clk);
        #1;
        start     = s;
        instr     = ins;
        mem_ready = rdy;
        @(negedge clk);
        check({tag, "_T"}, sel4 ? 32'(t4) : 32'(t15), 32'(exp_t));
        check(tag, sel4 ? 32'(outs4) : 32'(outs15), 32'(exp_o));
    endtask

    task automatic do_reset();
        start     = 1'b0;
        instr     = OP_NOP;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("rst15", 32'(outs15), 32'(B_E));
        check("rst4", 32'(outs4), 32'(B_E));
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_up(input bit sel4);
        cyc(sel4, 1'b0, OP_NOP, 1'b0, "idle",  2'd0, B_E);
        cyc(sel4, 1'b1, OP_NOP, 1'b0, "start", 2'd0, B_E);
        cyc(sel4, 1'b0, OP_NOP, 1'b0, "arm",   2'd0, NONE);
    endtask

    initial begin
        // Reset, start, CLR
        do_reset();
        start_up(0);
        cyc(0, 0, OP_CLR, 0, "clr_t0", 2'd0, B_IR);
        cyc(0, 0, OP_NOP, 0, "clr_t1", 2'd1, B_PCI);
        cyc(0, 0, OP_NOP, 0, "clr_t2", 2'd2, NONE);
        cyc(0, 0, OP_NOP, 0, "clr_t3", 2'd3, B_CLR);

        // LDA completing immediately
        cyc(0, 0, OP_LDA, 0, "lda_t0", 2'd0, B_IR);
        cyc(0, 0, OP_NOP, 0, "lda_t1", 2'd1, B_PCI);
        cyc(0, 0, OP_NOP, 1, "lda_t2", 2'd2, B_RD | B_LDM);
        cyc(0, 0, OP_NOP, 0, "lda_t3", 2'd3, NONE);

        // STA with three cycles of mem_ready low
        cyc(0, 0, OP_STA, 0, "sta_t0", 2'd0, B_IR);
        cyc(0, 0, OP_NOP, 0, "sta_t1", 2'd1, B_PCI);
        cyc(0, 0, OP_NOP, 0, "sta_t2", 2'd2, B_E | B_WR);
        cyc(0, 0, OP_NOP, 0, "sta_w1", 2'd2, B_E | B_WR);
        cyc(0, 0, OP_NOP, 0, "sta_w2", 2'd2, B_E | B_WR);
        cyc(0, 0, OP_NOP, 1, "sta_done", 2'd2, B_WR);

        // NOP: mem_ready has no effect
        cyc(0, 0, OP_NOP, 0, "nop_t0", 2'd0, B_IR);
        cyc(0, 0, OP_NOP, 1, "nop_t1", 2'd1, B_PCI);
        cyc(0, 0, OP_NOP, 1, "nop_t2", 2'd2, NONE);
        cyc(0, 0, OP_NOP, 1, "nop_t3", 2'd3, NONE);

        // JMP, ADD, INC
        cyc(0, 0, OP_JMP, 0, "jmp_t0", 2'd0, B_IR);
        cyc(0, 0, OP_NOP, 0, "jmp_t1", 2'd1, B_PCI);
        cyc(0, 0, OP_NOP, 0, "jmp_t2", 2'd2, B_PCL);
        cyc(0, 0, OP_NOP, 0, "jmp_t3", 2'd3, NONE);
        cyc(0, 0, OP_ADD, 0, "add_t0", 2'd0, B_IR);
        cyc(0, 0, OP_NOP, 0, "add_t1", 2'd1, B_PCI);
        cyc(0, 0, OP_NOP, 1, "add_t2", 2'd2, NONE);
        cyc(0, 0, OP_NOP, 0, "add_t3", 2'd3, B_ADD);
        cyc(0, 0, OP_INC, 0, "inc_t0", 2'd0, B_IR);
        cyc(0, 0, OP_NOP, 0, "inc_t1", 2'd1, B_PCI);
        cyc(0, 0, OP_NOP, 0, "inc_t2", 2'd2, NONE);
        cyc(0, 0, OP_NOP, 0, "inc_t3", 2'd3, B_INC);

        // HLT, then start ignored
        cyc(0, 0, OP_HLT, 0, "hlt_t0", 2'd0, B_IR);
        cyc(0, 0, OP_NOP, 0, "hlt_t1", 2'd1, B_PCI);
        cyc(0, 0, OP_NOP, 0, "hlt_t2", 2'd2, B_E);
        cyc(0, 0, OP_NOP, 0, "halt1",  2'd2, B_E | B_HLT);
        cyc(0, 1, OP_NOP, 0, "halt_st", 2'd2, B_E | B_HLT);
        cyc(0, 0, OP_NOP, 0, "halt2",  2'd2, B_E | B_HLT);

        // rst clears halted and returns to IDLE
        do_reset();
        cyc(0, 0, OP_NOP, 0, "post_hlt_idle", 2'd0, B_E);

        // LDA timeout on the TIMEOUT=4 instance
        do_reset();
        start_up(1);
        cyc(1, 0, OP_LDA, 0, "to_t0", 2'd0, B_IR);
        cyc(1, 0, OP_NOP, 0, "to_t1", 2'd1, B_PCI);
        cyc(1, 0, OP_NOP, 0, "to_t2", 2'd2, B_E | B_RD);
        cyc(1, 0, OP_NOP, 0, "to_w1", 2'd2, B_E | B_RD);
        cyc(1, 0, OP_NOP, 0, "to_w2", 2'd2, B_E | B_RD);
        cyc(1, 0, OP_NOP, 0, "to_w3", 2'd2, B_E | B_RD);
        cyc(1, 0, OP_NOP, 0, "to_w4", 2'd2, B_E);
        cyc(1, 0, OP_NOP, 0, "to_halt", 2'd2, B_E | B_HLT | B_ERR);
        cyc(1, 1, OP_NOP, 1, "to_start", 2'd2, B_E | B_HLT | B_ERR);
        cyc(1, 0, OP_NOP, 0, "to_hold", 2'd2, B_E | B_HLT | B_ERR);

        // Async reset in the middle of a WAIT, away from any clock edge
        do_reset();
        start_up(0);
        cyc(0, 0, OP_STA, 0, "ar_t0", 2'd0, B_IR);
        cyc(0, 0, OP_NOP, 0, "ar_t1", 2'd1, B_PCI);
        cyc(0, 0, OP_NOP, 0, "ar_t2", 2'd2, B_E | B_WR);
        cyc(0, 0, OP_NOP, 0, "ar_w1", 2'd2, B_E | B_WR);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_out", 32'(outs15), 32'(B_E));
        check("async_rst_T", 32'(t15), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, OP_NOP, 0, "ar_idle", 2'd0, B_E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
